// File: rtl/answer_judge_if.sv
// Bus between the game controller and the answer judge. It carries the round
// control, the raw buttons and the verdict/score outputs.
interface answer_judge_if #(
  parameter int SCORE_W = 8
);
  logic               round_start;
  logic [3:0]         expected_mask;
  logic [3:0]         keys;
  logic               score_clear;
  logic               busy;
  logic               result_valid;
  logic               correct;
  logic               timed_out;
  logic [1:0]         pressed_key;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  modport master (
    output round_start, expected_mask, keys, score_clear,
    input  busy, result_valid, correct, timed_out, pressed_key, score, game_over
  );

  modport slave (
    input  round_start, expected_mask, keys, score_clear,
    output busy, result_valid, correct, timed_out, pressed_key, score, game_over
  );
endinterface

// File: rtl/answer_judge.sv
// Player-response judge: arms a timed round, synchronises and edge-detects the
// four buttons, and judges the first press (or the timeout) against the latched mask.
module answer_judge #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int CNT_W          = 27,
  parameter int SCORE_W        = 8
) (
  input  logic           clock,
  input  logic           resetn,
  answer_judge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    ARMED        = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         prev_q, prev_d;
  logic [3:0]         mask_q, mask_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               result_valid_q, result_valid_d;
  logic               correct_q, correct_d;
  logic               timed_out_q, timed_out_d;
  logic [1:0]         pressed_key_q, pressed_key_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_over_q, game_over_d;

  logic [3:0] press_evt;
  logic       multi_press;
  logic [1:0] low_idx;
  logic       timeout_hit;
  logic       accept;
  logic       verdict;
  logic       verdict_correct;

  // Two-flop synchroniser followed by a previous-value register for edge detection.
  always_comb begin
    sync1_d   = bus.keys;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    press_evt = sync2_q & ~prev_q;
  end

  always_comb begin
    low_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (press_evt[k]) begin
        low_idx = 2'(k);
      end
    end
    multi_press = |(press_evt & (press_evt - 4'd1));
    timeout_hit = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));
    accept      = ((state_q == IDLE) || (state_q == DONE)) &&
                  bus.round_start && !game_over_q;
  end

  // Round sequencing and verdict; a press beats a same-cycle timeout.
  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    timer_d         = timer_q;
    result_valid_d  = 1'b0;
    correct_d       = correct_q;
    timed_out_d     = timed_out_q;
    pressed_key_d   = pressed_key_q;
    verdict         = 1'b0;
    verdict_correct = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          mask_d  = bus.expected_mask;
          timer_d = '0;
          state_d = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        if (sync2_q == 4'd0) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        timer_d = timer_q + CNT_W'(1);
        if (|press_evt) begin
          verdict         = 1'b1;
          verdict_correct = multi_press ? 1'b0 : mask_q[low_idx];
          pressed_key_d   = low_idx;
          timed_out_d     = 1'b0;
        end else if (timeout_hit) begin
          verdict         = 1'b1;
          verdict_correct = (mask_q == 4'd0);
          pressed_key_d   = 2'd0;
          timed_out_d     = 1'b1;
        end
        if (verdict) begin
          correct_d      = verdict_correct;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Score saturates at all-ones; a coincident clear overrides the verdict.
  always_comb begin
    score_d     = score_q;
    game_over_d = game_over_q;
    if (verdict) begin
      if (verdict_correct) begin
        if (score_q != '1) begin
          score_d = score_q + SCORE_W'(1);
        end
      end else begin
        game_over_d = 1'b1;
      end
    end
    if (bus.score_clear) begin
      score_d     = '0;
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      sync1_q        <= 4'd0;
      sync2_q        <= 4'd0;
      prev_q         <= 4'd0;
      mask_q         <= 4'd0;
      timer_q        <= '0;
      result_valid_q <= 1'b0;
      correct_q      <= 1'b0;
      timed_out_q    <= 1'b0;
      pressed_key_q  <= 2'd0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      mask_q         <= mask_d;
      timer_q        <= timer_d;
      result_valid_q <= result_valid_d;
      correct_q      <= correct_d;
      timed_out_q    <= timed_out_d;
      pressed_key_q  <= pressed_key_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.busy         = (state_q == WAIT_RELEASE) || (state_q == ARMED);
  assign bus.result_valid = result_valid_q;
  assign bus.correct      = correct_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.pressed_key  = pressed_key_q;
  assign bus.score        = score_q;
  assign bus.game_over    = game_over_q;

endmodule
